rr_merge_stage: RTL and testbench
=================================

// Module: rr_merge_stage
// PURPOSE
//  Downstream merge stage for the five sibling instances under one hierarchy node.
//  Each sibling drives a valid/ready stream into this block.
//  The block arbitrates the streams round-robin and buffers the winners in a small FIFO.
//  It presents one tagged output stream to the next level of the tree.
// PARAMETERS
//  N_IN    5   number of upstream streams (>=2)
//  DATA_W  32  payload width per stream
//  DEPTH   4   FIFO entries (power of two, >=2)
// PORTS
//  clk        in   1           single clock, rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   N_IN        per-stream valid
//  in_ready   out  N_IN        per-stream ready (one-hot or zero)
//  in_data    in   N_IN*DATA_W stream i occupies bits [i*DATA_W +: DATA_W]
//  out_valid  out  1           FIFO head valid
//  out_ready  in   1           downstream accept
//  out_data   out  DATA_W      head payload
//  out_src    out  SRC_W       head source index, SRC_W=$clog2(N_IN)
//  grant_cnt  out  N_IN*16     per-source grant counters (RR_MERGE_STATS_EN only)
// BEHAVIOUR
//  - Reset: rr_ptr=0, FIFO empty, count=0, out_valid=0, out_data=0, out_src=0, in_ready=0.
//  - Reset wins over any same-cycle push or pop.
//  - A reset mid-stream discards all buffered entries and produces no output beat.
//  - can_push = (count<DEPTH) | (out_valid & out_ready); pop-and-push when full is legal.
//  - Grant: if can_push, grant the first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N_IN.
//    in_ready = onehot(grant), combinational from in_valid, rr_ptr and FIFO state.
//  - When a grant fires: write {i, in_data[i]} at wr_ptr, and set rr_ptr <= (i+1) mod N_IN.
//    If no grant fires, rr_ptr holds.
//  - Latency: an entry accepted into an empty FIFO at edge k drives out_valid=1 with that entry after edge k.
//  - out_data/out_src come from registered FIFO storage at rd_ptr; no combinational in->out path.
//  - Pop when out_valid & out_ready. Pointers wrap modulo DEPTH.
//    Count update: +1 push only, -1 pop only, hold when push and pop coincide or when idle.
//  - Full (count==DEPTH) with no pop: in_ready=0 for all streams, and rr_ptr holds.
//  - Empty: out_valid=0; out_data/out_src hold their last value (don't-care).
//  - Upstream rule: in_valid/in_data must be stable while in_valid=1 && in_ready=0. The bench checks this.
// CONFIGURATION
//  - RR_MERGE_STATS_EN defined: port grant_cnt exists.
//    Per-source 16-bit counters clear on rst, increment on each grant to that source, saturate at 16'hFFFF.
//  - Not defined: grant_cnt port and counters are absent; all other behaviour is identical.
// STRUCTURE
//  - Package rr_merge_pkg: RR_CNT_W=16, the function rr_next(ptr,n) returning (ptr+1)%n,
//    and a parameterised entry struct {src, data} typedef.
//  - Sub-module rr_merge_fifo: sync FIFO with push/pop, full/empty and count ports.
//    The arbiter and the optional counters stay in the top module.
// TESTING
//  1. Reset with all in_valid=1: in_ready=0 and out_valid=0 during reset.
//     On the first cycle after reset, stream 0 is granted.
//  2. All five valid, out_ready=1 forever: out_src sequence is 0,1,2,3,4,0,...
//     One beat per cycle, and data matches each source's counter pattern.
//  3. out_ready=0, all valid: exactly 4 grants (src 0..3), then in_ready=0.
//     Set out_ready=1: pop and push occur in the same cycle, and the next grant goes to src 4.
//  4. Only streams 1 and 3 valid, rr_ptr=2: stream 3 is granted first, then 1, 3, 1, ... alternately.
//  5. Assert rst with 3 entries buffered: the next cycle has out_valid=0 and count=0.
//     The first post-reset grant goes to the lowest valid index.
//  6. With RR_MERGE_STATS_EN: 70000 grants to src 2 leave grant_cnt[2]=16'hFFFF, and the other counters stay 0.

Source files
------------

// File: rtl/rr_merge_pkg.sv
// Shared definitions for the round-robin merge stage: counter width, pointer
// advance helper and the default-width FIFO entry layout.
package rr_merge_pkg;

  localparam int unsigned RR_CNT_W = 16;

  // Default geometry; the top module re-declares the entry against its own parameters.
  localparam int unsigned RR_N_IN_DEF   = 5;
  localparam int unsigned RR_DATA_W_DEF = 32;
  localparam int unsigned RR_SRC_W_DEF  = $clog2(RR_N_IN_DEF);

  typedef struct packed {
    logic [RR_SRC_W_DEF-1:0]  src;
    logic [RR_DATA_W_DEF-1:0] data;
  } rr_entry_t;

  // Next round-robin position after ptr among n streams.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1) % n;
  endfunction

endpackage

// File: rtl/rr_merge_fifo.sv
// Synchronous FIFO for the merge stage. Storage is cleared on reset so the head
// reads as zero until the first entry lands. DEPTH must be a power of two.
module rr_merge_fifo #(
  parameter  int unsigned WIDTH = 35,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // State and storage; reset overrides any same-cycle push or pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/rr_merge_stage.sv
// Round-robin merge of N_IN valid/ready streams into one tagged output stream,
// buffered through rr_merge_fifo. Define RR_MERGE_STATS_EN to add the
// per-source saturating grant counters on port grant_cnt_o.
module rr_merge_stage import rr_merge_pkg::*; #(
  parameter  int unsigned N_IN   = 5,
  parameter  int unsigned DATA_W = 32,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned SRC_W  = $clog2(N_IN)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_IN-1:0]        in_valid_i,
  output logic [N_IN-1:0]        in_ready_o,
  input  logic [N_IN*DATA_W-1:0] in_data_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [DATA_W-1:0]      out_data_o,
  output logic [SRC_W-1:0]       out_src_o
`ifdef RR_MERGE_STATS_EN
  ,
  output logic [N_IN*RR_CNT_W-1:0] grant_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [SRC_W-1:0]  src;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t           wr_entry, rd_entry;
  logic             fifo_full, fifo_empty, fifo_pop, can_push;
  logic [CNT_W-1:0] fifo_count;
  logic             grant_fire;
  logic [SRC_W-1:0] grant_idx;
  logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;

  assign out_valid_o = ~fifo_empty;
  assign fifo_pop    = out_valid_o & out_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign can_push    = ~fifo_full | fifo_pop;

  // Grant the first valid stream at or after rr_ptr; candidate ptr+k may exceed N_IN-1 once.
  always_comb begin
    grant_fire = 1'b0;
    grant_idx  = '0;
    if (!rst_i && can_push) begin
      for (int unsigned k = 0; k < N_IN; k++) begin
        for (int unsigned i = 0; i < N_IN; i++) begin
          if (!grant_fire && in_valid_i[i] &&
              ((32'(rr_ptr_q) + k == i) || (32'(rr_ptr_q) + k == i + N_IN))) begin
            grant_fire = 1'b1;
            grant_idx  = SRC_W'(i);
          end
        end
      end
    end
  end

  // One-hot ready plus the payload mux for the granted stream.
  always_comb begin
    in_ready_o    = '0;
    wr_entry.src  = grant_idx;
    wr_entry.data = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (grant_idx == SRC_W'(i)) begin
        wr_entry.data = in_data_i[i*DATA_W +: DATA_W];
        in_ready_o[i] = grant_fire;
      end
    end
  end

  // Pointer advances past the winner; holds when nothing is granted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_fire) rr_ptr_d = SRC_W'(rr_next(32'(grant_idx), N_IN));
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  rr_merge_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (grant_fire),
    .pop_i   (fifo_pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Full flag and occupancy count must agree.
  assert property (@(posedge clk_i) disable iff (rst_i)
                   fifo_full == (32'(fifo_count) == DEPTH));

  assign out_data_o = rd_entry.data;
  assign out_src_o  = rd_entry.src;

`ifdef RR_MERGE_STATS_EN
  logic [RR_CNT_W-1:0] cnt_q [N_IN];

  // Per-source grant counters, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_IN; i++) cnt_q[i] <= '0;
    end else if (grant_fire && (cnt_q[grant_idx] != '1)) begin
      cnt_q[grant_idx] <= cnt_q[grant_idx] + RR_CNT_W'(1);
    end
  end

  // Flatten counters onto the output port.
  always_comb begin
    grant_cnt_o = '0;
    for (int unsigned i = 0; i < N_IN; i++) grant_cnt_o[i*RR_CNT_W +: RR_CNT_W] = cnt_q[i];
  end
`endif

endmodule

// File: tb/tb_rr_merge_stage.sv
// Bench for rr_merge_stage: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_rr_merge_stage;

  localparam int N     = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N-1:0]    in_ready;
  logic [N*DW-1:0] in_data = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [DW-1:0]   out_data;
  logic [2:0]      out_src;
`ifdef RR_MERGE_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  always #5 clk = ~clk;

  rr_merge_stage #(
    .N_IN   (N),
    .DATA_W (DW),
    .DEPTH  (DEPTH)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_src_o   (out_src)
`ifdef RR_MERGE_STATS_EN
    ,
    .grant_cnt_o (grant_cnt)
`endif
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as a queue, pointer as a plain integer.
  typedef struct {
    int            src;
    logic [DW-1:0] data;
  } ent_t;

  ent_t         mq[$];
  int           m_ptr = 0;
  bit           model_ok = 1'b0;
  bit           m_fire = 1'b0;
  int           m_idx = 0;
  bit           m_pop = 1'b0;
  int           m_cnt[N];
  logic [N-1:0]    pend = '0;
  logic [N*DW-1:0] pend_data = '0;

  // Compare process: derive expected outputs from the model and the current inputs.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    bit           can;
    if (model_ok) begin
      exp_ready = '0;
      m_fire    = 1'b0;
      m_idx     = 0;
      m_pop     = (mq.size() > 0) && out_ready && !rst;
      can       = (mq.size() < DEPTH) || m_pop;
      if (!rst && can) begin
        for (int k = 0; k < N; k++) begin
          int s;
          s = (m_ptr + k) % N;
          if (!m_fire && in_valid[s]) begin
            m_fire = 1'b1;
            m_idx  = s;
          end
        end
      end
      if (m_fire) exp_ready[m_idx] = 1'b1;
      chk("model_in_ready", 64'(in_ready), 64'(exp_ready));
      chk("model_out_valid", 64'(out_valid), 64'(mq.size() > 0));
      if (mq.size() > 0) begin
        chk("model_out_src", 64'(out_src), 64'(mq[0].src));
        chk("model_out_data", 64'(out_data), 64'(mq[0].data));
      end
`ifdef RR_MERGE_STATS_EN
      for (int i = 0; i < N; i++) chk("model_grant_cnt", 64'(grant_cnt[i*16 +: 16]), 64'(m_cnt[i]));
`endif
      if (!rst) begin
        for (int i = 0; i < N; i++) begin
          if (pend[i])
            chk("upstream_hold", {31'd0, in_valid[i], in_data[i*DW +: DW]},
                {31'd0, 1'b1, pend_data[i*DW +: DW]});
        end
      end
      pend      = rst ? '0 : (in_valid & ~in_ready);
      pend_data = in_data;
    end
  end

  // Model state update at the active edge.
  always @(posedge clk) begin
    ent_t e;
    if (rst) begin
      mq.delete();
      m_ptr    = 0;
      for (int i = 0; i < N; i++) m_cnt[i] = 0;
      model_ok = 1'b1;
    end else if (model_ok) begin
      if (m_pop) void'(mq.pop_front());
      if (m_fire) begin
        e.src  = m_idx;
        e.data = in_data[m_idx*DW +: DW];
        mq.push_back(e);
        m_ptr = (m_idx + 1) % N;
        if (m_cnt[m_idx] < 65535) m_cnt[m_idx]++;
      end
    end
  end

  // Stimulus: each stream presents {src, per-stream sequence number}.
  int           seq[N];
  logic [N-1:0] hs;

  task automatic refresh();
    for (int i = 0; i < N; i++) in_data[i*DW +: DW] = {8'(i), 24'(seq[i])};
  endtask

  task automatic neg();
    @(negedge clk);
    #1;
    hs = in_valid & in_ready;
  endtask

  task automatic pos();
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) seq[i]++;
    refresh();
  endtask

  task automatic tick();
    neg();
    pos();
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    rst      = 1'b1;
    in_valid = v;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int            srcs[$];
    logic [DW-1:0] datas[$];
    int            iters;
    int            exp_src[6];
    logic [DW-1:0] exp_data[6];
    logic [N-1:0]  one;
    logic [N-1:0]  alt[4];

    one = 1;
    for (int i = 0; i < N; i++) seq[i] = 0;
    refresh();

    // 1: reset with every stream valid.
    rst       = 1'b1;
    in_valid  = '1;
    out_ready = 1'b1;
    repeat (2) begin
      neg();
      chk("rst_in_ready", 64'(in_ready), 64'(0));
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_out_src", 64'(out_src), 64'(0));
      pos();
    end
    rst = 1'b0;
    neg();
    chk("first_grant", 64'(in_ready), 64'(5'b00001));
    pos();

    // 2: all valid, always ready: one beat per cycle, sources in rotation.
    exp_src  = '{0, 1, 2, 3, 4, 0};
    exp_data = '{32'h0000_0000, 32'h0100_0000, 32'h0200_0000, 32'h0300_0000,
                 32'h0400_0000, 32'h0000_0001};
    iters = 0;
    for (int c = 0; c < 20 && srcs.size() < 6; c++) begin
      neg();
      if (out_valid && out_ready) begin
        srcs.push_back(int'(out_src));
        datas.push_back(out_data);
      end
      pos();
      iters++;
    end
    chk("rotation_pops", 64'(srcs.size()), 64'(6));
    chk("rotation_cycles", 64'(iters), 64'(6));
    for (int i = 0; i < srcs.size() && i < 6; i++) begin
      chk("rotation_src", 64'(srcs[i]), 64'(exp_src[i]));
      chk("rotation_data", 64'(datas[i]), 64'(exp_data[i]));
    end

    // 3: stalled output fills the FIFO with src 0..3, then pop-and-push grants src 4.
    out_ready = 1'b0;
    do_reset('1);
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("fill_grant", 64'(in_ready), 64'(one << k));
      pos();
    end
    repeat (2) begin
      neg();
      chk("full_no_ready", 64'(in_ready), 64'(0));
      chk("full_head_src", 64'(out_src), 64'(0));
      pos();
    end
    out_ready = 1'b1;
    neg();
    chk("pop_push_grant", 64'(in_ready), 64'(5'b10000));
    chk("pop_head_src", 64'(out_src), 64'(0));
    pos();
    neg();
    chk("after_pop_src", 64'(out_src), 64'(1));
    pos();

    // 4: pointer at 2 with only streams 1 and 3 valid.
    do_reset(5'b00010);
    neg();
    chk("alt_setup", 64'(in_ready), 64'(5'b00010));
    pos();
    in_valid = 5'b01010;
    alt = '{5'b01000, 5'b00010, 5'b01000, 5'b00010};
    for (int k = 0; k < 4; k++) begin
      neg();
      chk("alt_grant", 64'(in_ready), 64'(alt[k]));
      pos();
    end

    // 5: reset with three entries buffered discards them.
    out_ready = 1'b0;
    do_reset('1);
    repeat (2) tick();
    neg();
    chk("buffered_valid", 64'(out_valid), 64'(1));
    pos();
    rst      = 1'b1;
    in_valid = 5'b10100;
    tick();
    rst = 1'b0;
    neg();
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    chk("post_rst_grant", 64'(in_ready), 64'(5'b00100));
    pos();
    neg();
    chk("post_rst_head", 64'(out_src), 64'(2));
    pos();

`ifdef RR_MERGE_STATS_EN
    // 6: saturation of a single source's grant counter.
    out_ready = 1'b1;
    do_reset(5'b00100);
    repeat (100) tick();
    chk("cnt_100", 64'(grant_cnt[2*16 +: 16]), 64'(100));
    repeat (69900) tick();
    chk("cnt_sat", 64'(grant_cnt[2*16 +: 16]), 64'(16'hFFFF));
    for (int i = 0; i < N; i++)
      if (i != 2) chk("cnt_other", 64'(grant_cnt[i*16 +: 16]), 64'(0));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
